// File: rtl/uart_pkg.sv
// Shared definitions for bus_uart_tx: register offsets, bit indices, TX states, divisor helpers.
// Defining UART_PARITY_EN adds the PARITY state to the TX state enum.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_LVL_LSB = 3;
  localparam int STAT_LVL_MSB = 8;
  localparam int STAT_OVF     = 9;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_PAR_ODD = 1;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } tx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // STATUS has only six level bits; a 64-deep FIFO reports 63 when full.
  function automatic logic [5:0] sat_level(input logic [6:0] lvl);
    return (lvl > 7'd63) ? 6'd63 : lvl[5:0];
  endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// Register bus between a bus master and bus_uart_tx.
// cs is a level held by the master until bus_ack; zero bytesel means read.
interface bus_uart_tx_if;
  logic        cs;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic [3:0]  bus_bytesel;
  logic        bus_ack;
  logic [31:0] bus_data;

  modport master (
    output cs, bus_addr, bus_wr_val, bus_bytesel,
    input  bus_ack, bus_data
  );

  modport slave (
    input  cs, bus_addr, bus_wr_val, bus_bytesel,
    output bus_ack, bus_data
  );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead read port and occupancy level.
// A pop frees a slot for a push in the same cycle, even when full.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter: register decode, TX FIFO and serialiser FSM, level interrupt.
// Define UART_PARITY_EN to insert a parity bit; CTRL bit1 then selects odd parity.
//
// state  | meaning
// IDLE   | line high, waiting for FIFO data
// START  | start bit (0), DIV clocks
// DATA   | 8 data bits LSB first, DIV clocks each
// PARITY | parity bit (UART_PARITY_EN builds only)
// STOP   | stop bit (1); chains straight into START if more data waits
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic         clk,
  input  logic         resetn,
  bus_uart_tx_if.slave bus,
  output logic         txd,
  output logic         intr,
  input  logic         intack
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RESET = clamp_div(DEFAULT_DIV[15:0]);

  logic          served;
  logic          acc;
  logic          wr_acc;
  logic          rd_acc;
  logic [1:0]    reg_sel;
  logic          push;
  logic          ctrl_wr;
  logic          div_wr_en;
  logic [15:0]   div_wr;
  logic          irq_en;
  logic          ovf;
  logic [15:0]   div_reg;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          irq_clr;
`ifdef UART_PARITY_EN
  logic          par_odd;
  logic          par_bit;
  logic          par_bit_n;
`endif

  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [LW-1:0] level;

  tx_state_e     state;
  tx_state_e     state_n;
  logic [15:0]   cnt;
  logic [15:0]   cnt_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic          tc;
  logic          frame_done;

  logic          unused_bus;
  assign unused_bus = ^{bus.bus_addr[31:4], bus.bus_addr[1:0],
                        bus.bus_wr_val[31:16], bus.bus_bytesel[3:2]};

  // served follows cs, so acc is high only on the first cycle of each cs assertion.
  assign acc       = bus.cs & ~served;
  assign wr_acc    = acc & (bus.bus_bytesel != 4'b0000);
  assign rd_acc    = acc & (bus.bus_bytesel == 4'b0000);
  assign reg_sel   = bus.bus_addr[3:2];
  assign push      = wr_acc & bus.bus_bytesel[0] & (reg_sel == REG_DATA);
  assign ctrl_wr   = wr_acc & bus.bus_bytesel[0] & (reg_sel == REG_CTRL);
  assign div_wr_en = wr_acc & (bus.bus_bytesel[1:0] != 2'b00) & (reg_sel == REG_DIV);
  assign div_wr    = clamp_div({bus.bus_bytesel[1] ? bus.bus_wr_val[15:8] : div_reg[15:8],
                                bus.bus_bytesel[0] ? bus.bus_wr_val[7:0]  : div_reg[7:0]});
  assign irq_clr   = intack | (ctrl_wr & ~bus.bus_wr_val[CTRL_IRQ_EN]);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (bus.bus_wr_val[7:0]),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    status                            = '0;
    status[STAT_FULL]                 = full;
    status[STAT_EMPTY]                = empty;
    status[STAT_BUSY]                 = (state != IDLE);
    status[STAT_LVL_MSB:STAT_LVL_LSB] = sat_level(7'(level));
    status[STAT_OVF]                  = ovf;
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = status;
      REG_CTRL: begin
        rdata[CTRL_IRQ_EN] = irq_en;
`ifdef UART_PARITY_EN
        rdata[CTRL_PAR_ODD] = par_odd;
`endif
      end
      REG_DIV:  rdata[15:0] = div_reg;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      served       <= 1'b0;
      bus.bus_ack  <= 1'b0;
      bus.bus_data <= '0;
      irq_en       <= 1'b0;
      ovf          <= 1'b0;
      div_reg      <= DIV_RESET;
`ifdef UART_PARITY_EN
      par_odd      <= 1'b0;
`endif
    end else begin
      served       <= bus.cs;
      bus.bus_ack  <= acc;
      bus.bus_data <= rd_acc ? rdata : '0;
      if (ctrl_wr) begin
        irq_en <= bus.bus_wr_val[CTRL_IRQ_EN];
`ifdef UART_PARITY_EN
        par_odd <= bus.bus_wr_val[CTRL_PAR_ODD];
`endif
      end
      if (div_wr_en) div_reg <= div_wr;
      // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (rd_acc && reg_sel == REG_STATUS)
        ovf <= 1'b0;
    end
  end

  // Counter is reloaded from div_reg only at bit boundaries, so DIV writes never cut a bit short.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    bit_n      = bit_idx;
    pop        = 1'b0;
    frame_done = 1'b0;
    tc         = (cnt == 16'd0);
`ifdef UART_PARITY_EN
    par_bit_n  = par_bit;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = head;
          cnt_n   = div_reg - 16'd1;
          state_n = START;
`ifdef UART_PARITY_EN
          par_bit_n = (^head) ^ par_odd;
`endif
        end
      end
      START: begin
        if (tc) begin
          state_n = DATA;
          bit_n   = 3'd0;
          cnt_n   = div_reg - 16'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (tc) begin
          cnt_n = div_reg - 16'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            sh_n  = sh >> 1;
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tc) begin
          state_n = STOP;
          cnt_n   = div_reg - 16'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (tc) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = head;
            cnt_n   = div_reg - 16'd1;
            state_n = START;
`ifdef UART_PARITY_EN
            par_bit_n = (^head) ^ par_odd;
`endif
          end else begin
            state_n    = IDLE;
            frame_done = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      bit_idx <= '0;
`ifdef UART_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      bit_idx <= bit_n;
`ifdef UART_PARITY_EN
      par_bit <= par_bit_n;
`endif
    end
  end

  always_comb begin
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = sh[0];
`ifdef UART_PARITY_EN
      PARITY:  txd = par_bit;
`endif
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      intr <= 1'b0;
    else if (frame_done && irq_en)
      intr <= 1'b1;
    else if (irq_clr)
      intr <= 1'b0;
  end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register vector table plus serial-frame, interrupt,
// overflow and reset sequences. Honours UART_PARITY_EN when the design is built with it.
module tb_bus_uart_tx;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic intack = 1'b0;
  logic txd;
  logic intr;
  int   checks = 0;
  int   failures = 0;
  logic par_odd_m = 1'b0;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] CTRL_ALL = 32'h3;
`else
  localparam int NB = 10;
  localparam logic [31:0] CTRL_ALL = 32'h1;
`endif

  always #5 clk = ~clk;

  bus_uart_tx_if bus();

  bus_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .txd    (txd),
    .intr   (intr),
    .intack (intack)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One idle cycle first so the DUT sees cs low, then one access; returns 1ns after the ack edge.
  task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs,
                            output logic [31:0] rd, output logic ack);
    @(posedge clk); #1;
    bus.cs          = 1'b1;
    bus.bus_addr    = a;
    bus.bus_wr_val  = d;
    bus.bus_bytesel = bs;
    @(posedge clk); #1;
    ack = bus.bus_ack;
    rd  = bus.bus_data;
    bus.cs          = 1'b0;
    bus.bus_bytesel = 4'h0;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
    logic [31:0] rd;
    logic ack;
    bus_access(a, d, bs, rd, ack);
    check({name, " ack"}, {31'b0, ack}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic ack;
    bus_access(a, 32'h0, 4'h0, rd, ack);
    check({name, " ack"}, {31'b0, ack}, 32'h1);
    check(name, rd, exp);
  endtask

  // Called right after the DATA write ack. irq_mode: 0 ignore intr, 1 expect rise at frame end,
  // 2 also pulse intack on the very cycle of the rise (set must win).
  task automatic track_frame(input logic [7:0] b, input int w0, input int w, input bit poke_div,
                             input int irq_mode, input string tag);
    int   total;
    int   idx;
    logic exp_bit;
    logic par;
    par   = par_odd_m ? ~(^b) : ^b;
    total = w0 + (NB - 1) * w;
    check({tag, " txd before start"}, {31'b0, txd}, 32'h1);
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      if (poke_div && k == 5) begin
        check({tag, " div poke ack"}, {31'b0, bus.bus_ack}, 32'h1);
        bus.cs          = 1'b0;
        bus.bus_bytesel = 4'h0;
      end
      idx = (k < w0) ? 0 : 1 + (k - w0) / w;
      if (idx == 0)           exp_bit = 1'b0;
      else if (idx <= 8)      exp_bit = b[idx-1];
      else if (idx == NB - 1) exp_bit = 1'b1;
      else                    exp_bit = par;
      check($sformatf("%s bit%0d cyc%0d", tag, idx, k), {31'b0, txd}, {31'b0, exp_bit});
      if (poke_div && k == 4) begin
        bus.cs          = 1'b1;
        bus.bus_addr    = 32'hC;
        bus.bus_wr_val  = 32'h8;
        bus.bus_bytesel = 4'h1;
      end
      if (k == total - 1 && irq_mode != 0) begin
        check({tag, " int before frame end"}, {31'b0, intr}, 32'h0);
        if (irq_mode == 2) intack = 1'b1;
      end
    end
    @(posedge clk); #1;
    intack = 1'b0;
    check({tag, " txd idle after stop"}, {31'b0, txd}, 32'h1);
    if (irq_mode != 0) check({tag, " int at frame end"}, {31'b0, intr}, 32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    vecs[0]  = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h2};
    vecs[1]  = '{1'b0, 32'h8,  32'h0,        4'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'hC,  32'h0,        4'h0, 32'd16};
    vecs[3]  = '{1'b1, 32'hC,  32'h1234,     4'h3, 32'h0};
    vecs[4]  = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h1234};
    vecs[5]  = '{1'b1, 32'hC,  32'hAB00,     4'h2, 32'h0};
    vecs[6]  = '{1'b0, 32'hC,  32'h0,        4'h0, 32'hAB34};
    vecs[7]  = '{1'b1, 32'hC,  32'h0001,     4'h3, 32'h0};
    vecs[8]  = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h2};
    vecs[9]  = '{1'b1, 32'hC,  32'h0700,     4'h2, 32'h0};
    vecs[10] = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h0702};
    vecs[11] = '{1'b1, 32'hC,  32'hFFFF0000, 4'h3, 32'h0};
    vecs[12] = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h2};
    vecs[13] = '{1'b1, 32'h8,  32'hFFFFFFFF, 4'h1, 32'h0};
    vecs[14] = '{1'b0, 32'h8,  32'h0,        4'h0, CTRL_ALL};
    vecs[15] = '{1'b1, 32'h8,  32'h0,        4'h2, 32'h0};
    vecs[16] = '{1'b0, 32'h8,  32'h0,        4'h0, CTRL_ALL};
    vecs[17] = '{1'b1, 32'h8,  32'h0,        4'h1, 32'h0};
    vecs[18] = '{1'b0, 32'h8,  32'h0,        4'h0, 32'h0};
    vecs[19] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'h0};
    vecs[20] = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h2};
    vecs[21] = '{1'b1, 32'hC,  32'd16,       4'h1, 32'h0};
    vecs[22] = '{1'b0, 32'hC,  32'h0,        4'h0, 32'd16};
    vecs[23] = '{1'b1, 32'h0,  32'h55,       4'h2, 32'h0};
    vecs[24] = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h2};

    bus.cs          = 1'b0;
    bus.bus_addr    = 32'h0;
    bus.bus_wr_val  = 32'h0;
    bus.bus_bytesel = 4'h0;

    #3;
    check("reset txd", {31'b0, txd}, 32'h1);
    check("reset ack", {31'b0, bus.bus_ack}, 32'h0);
    check("reset data", bus.bus_data, 32'h0);
    check("reset int", {31'b0, intr}, 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].wr)
        wr($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].bs);
      else
        rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // cs held for four cycles: exactly one ack on the first, data zero once ack drops
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.bus_addr = 32'h4; bus.bus_bytesel = 4'h0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.bus_ack) acks++;
      if (c == 0) check("hold ack first cycle", {31'b0, bus.bus_ack}, 32'h1);
      if (c == 1) check("hold data after ack", bus.bus_data, 32'h0);
    end
    check("hold ack count", acks, 32'd1);
    bus.cs = 1'b0;

    wr("irq_en", 32'h8, 32'h1, 4'h1);
    wr("push 55", 32'h0, 32'h55, 4'h1);
    track_frame(8'h55, 16, 16, 1'b0, 1, "f55");
    intack = 1'b1;
    @(posedge clk); #1;
    intack = 1'b0;
    check("intack clears int", {31'b0, intr}, 32'h0);

    wr("push a3", 32'h0, 32'hA3, 4'h1);
    track_frame(8'hA3, 16, 16, 1'b0, 2, "fA3");

    wr("push 55 div", 32'h0, 32'h55, 4'h1);
    track_frame(8'h55, 16, 8, 1'b1, 0, "fdiv");
    rd_chk("div after poke", 32'hC, 32'd8);
    wr("div 1", 32'hC, 32'h1, 4'h1);
    rd_chk("div clamp", 32'hC, 32'd2);
    wr("push 55 fast", 32'h0, 32'h55, 4'h1);
    track_frame(8'h55, 2, 2, 1'b0, 0, "f2");
    wr("div 16", 32'hC, 32'd16, 4'h1);

`ifdef UART_PARITY_EN
    wr("ctrl odd", 32'h8, 32'h3, 4'h1);
    par_odd_m = 1'b1;
    wr("push 07", 32'h0, 32'h07, 4'h1);
    track_frame(8'h07, 16, 16, 1'b0, 0, "fpar");
`endif

    // reset in the middle of data bit 0 of a 0x00 frame
    check("int before reset", {31'b0, intr}, 32'h1);
    wr("push 00", 32'h0, 32'h00, 4'h1);
    repeat (20) @(posedge clk);
    #1;
    check("txd mid data", {31'b0, txd}, 32'h0);
    #3 resetn = 1'b0;
    #1;
    check("async reset txd", {31'b0, txd}, 32'h1);
    check("async reset int", {31'b0, intr}, 32'h0);
    check("async reset ack", {31'b0, bus.bus_ack}, 32'h0);
    check("async reset data", bus.bus_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rd_chk("status after reset", 32'h4, 32'h2);
    rd_chk("ctrl after reset", 32'h8, 32'h0);
    rd_chk("div after reset", 32'hC, 32'd16);
    check("int after reset", {31'b0, intr}, 32'h0);

    // overflow with the serialiser stalled in START
    wr("div ffff", 32'hC, 32'hFFFF, 4'h3);
    for (int i = 0; i < 9; i++) wr($sformatf("fill%0d", i), 32'h0, i + 1, 4'h1);
    rd_chk("status full", 32'h4, 32'h45);
    wr("push overflow", 32'h0, 32'hEE, 4'h1);
    rd_chk("status overflow", 32'h4, 32'h245);
    rd_chk("status overflow cleared", 32'h4, 32'h45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DEFAULT_DIV, default 16, clocks per serial bit after reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port cs, input, 1: bus select, level, held until bus_ack.
REQ-006 SHALL have port bus_addr, input, 32: byte address; only bits [3:2] decoded.
REQ-007 SHALL have port bus_wr_val, input, 32: write data.
REQ-008 SHALL have port bus_bytesel, input, 4: write strobes; zero means read.
REQ-009 SHALL have port bus_ack, output, 1: one-cycle access-complete pulse.
REQ-010 SHALL have port bus_data, output, 32: read data, valid while bus_ack is high.
REQ-011 SHALL have port txd, output, 1: serial line, idle high.
REQ-012 SHALL have port int, output, 1: level interrupt request.
REQ-013 SHALL have port intack, input, 1: one-cycle interrupt acknowledge.

Function
REQ-014 Register map SHALL be: 0x0 DATA (write pushes bits [7:0]), 0x4 STATUS (RO: bit0 full, bit1 empty, bit2 busy, bits[8:3] level), 0x8 CTRL (bit0 irq_en), 0xC DIV (bits[15:0]; values below 2 are clamped to 2).
REQ-015 bus_ack SHALL pulse exactly one cycle after the first cycle of cs, then stay low until cs deasserts for at least one cycle.
REQ-016 Writes SHALL take effect on the ack cycle; only bytesel[0] gates DATA, CTRL, and DIV[7:0]; bytesel[1] gates DIV[15:8].
REQ-017 A DATA write while the FIFO is full SHALL be dropped, still acked, and SHALL set sticky STATUS bit9 (overflow), cleared by any STATUS read.
REQ-018 Reads of DATA SHALL return 0.
REQ-019 TX FSM SHALL use states IDLE, START, DATA, PARITY (only when compiled in), STOP; each state lasts DIV clocks, counted by a 16-bit down-counter.
REQ-020 IDLE->START SHALL occur on the cycle the FIFO is non-empty; the pop SHALL occur on the same cycle.
REQ-021 Data bits SHALL be sent LSB first, 8 bits; STOP SHALL drive 1; STOP->START SHALL be back-to-back when the FIFO is non-empty, with no idle bit.
REQ-022 A push and a pop in the same cycle SHALL leave the level unchanged, including when the FIFO is full.
REQ-023 A DIV write SHALL take effect at the next bit boundary and SHALL NOT truncate the current bit.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 int SHALL set when irq_en=1 and the FSM enters IDLE with the FIFO empty; it SHALL clear on intack or when irq_en is written to 0; if set and clear coincide, set SHALL win.

Reset
REQ-026 While resetn=0, outputs SHALL be: txd=1, bus_ack=0, bus_data=0, int=0.
REQ-027 While resetn=0, state SHALL be: FSM=IDLE, FIFO empty, irq_en=0, overflow=0, DIV=DEFAULT_DIV.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and discard FIFO contents.

Configuration
REQ-029 With UART_PARITY_EN defined, CTRL bit1 SHALL select even parity (0) or odd parity (1), and the PARITY state SHALL be inserted between DATA and STOP.
REQ-030 Without UART_PARITY_EN, CTRL bit1 SHALL read 0 and ignore writes, and there SHALL be no PARITY state.

Structure
REQ-031 Package uart_pkg SHALL hold the register offsets, STATUS and CTRL bit indices, the FSM state enum, and the minimum divisor constant.
REQ-032 The FIFO SHALL be a sub-module uart_fifo (parameterised depth/width, push/pop/full/empty/level); the bus decode and the FSM SHALL stay in bus_uart_tx.

Verification
REQ-033 Write 0x55 to DATA with DIV=16: txd SHALL go low 1 cycle after ack and hold each bit 16 clocks (0,1,0,1,0,1,0,1,0 then stop 1); the frame SHALL be 160 clocks.
REQ-034 Push 9 bytes with FIFO_DEPTH=8 while the FSM is stalled by DIV=0xFFFF: the 9th byte SHALL be accepted because the first pop has occurred; the 10th SHALL set overflow, and a STATUS read SHALL return then clear bit9.
REQ-035 Set irq_en=1, send 1 byte: int SHALL rise when the stop bit ends; an intack pulse SHALL clear it; an intack coincident with a new set condition SHALL leave int high.
REQ-036 Write DIV=8 mid-bit at DIV=16: the current bit SHALL last 16 clocks and subsequent bits 8; writing DIV=1 SHALL give 2-clock bits.
REQ-037 Assert resetn=0 mid-data-bit: txd SHALL be 1 asynchronously, STATUS SHALL read empty=1 and level=0 after release, and int SHALL be 0.
REQ-038 With UART_PARITY_EN and CTRL bit1=1, send 0x07: the parity bit SHALL be 0, and the frame SHALL be 11 bits long.
